dm_port_arbiter: RTL

- Shares the single-port, synchronous-read 8-bit data memory between two requesters.
- Requester 1 is the pipeline MEM stage (cpu port). Requester 2 is an external loader/debug port (ext port) using a req/gnt handshake.
- cpu has fixed priority; a starvation counter forces an ext slot after STARVE_LIMIT lost cycles, stalling the pipeline for that cycle.
- Sits between the MEM stage and the data memory instance, driving its en/we/addr/din and steering dout back to the requester that issued the read.

---
 rtl/dm_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter in front of the single-port synchronous-read data memory.
// The pipeline (cpu) has priority; a starvation counter forces one ext slot after STARVE_LIMIT losses.
module dm_port_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_gnt,
   output logic          ext_rvalid,
   output logic [DW-1:0] ext_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic {
      ARB_CPU   = 1'b0,
      ARB_FORCE = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t state;
   logic [3:0] starve_cnt;
   logic [3:0] cnt_nxt;
   owner_t     rd_owner;
   owner_t     owner_nxt;
   logic       cpu_win;
   logic       ext_win;

   // Grant decision: cpu first, except in the single forced slot while ext still asks.
   always_comb begin
      cpu_win = 1'b0;
      ext_win = 1'b0;
      if (!reset) begin
         if (state == ARB_FORCE && ext_req) begin
            ext_win = 1'b1;
         end else if (cpu_req) begin
            cpu_win = 1'b1;
         end else if (ext_req) begin
            ext_win = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_nxt = starve_cnt;
      if (ext_win || !ext_req) begin
         cnt_nxt = 4'd0;
      end else if (cpu_win) begin
         cnt_nxt = starve_cnt + 4'd1;
      end
   end

   always_comb begin
      owner_nxt = OWN_NONE;
      if (cpu_win && !cpu_we) begin
         owner_nxt = OWN_CPU;
      end else if (ext_win && !ext_we) begin
         owner_nxt = OWN_EXT;
      end
   end

   always_comb begin
      mem_en   = cpu_win | ext_win;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (cpu_win) begin
         mem_we   = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (ext_win) begin
         mem_we   = ext_we;
         mem_addr = ext_addr;
         mem_din  = ext_wdata;
      end
   end

   assign ext_gnt   = ext_win;
   assign cpu_stall = cpu_req & ~cpu_win & ~reset;

   // Stage boundary: arbitration state and owner of the read returning next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ARB_CPU;
         starve_cnt <= 4'd0;
         rd_owner   <= OWN_NONE;
      end else begin
         starve_cnt <= cnt_nxt;
         rd_owner   <= owner_nxt;
         case (state)
            ARB_CPU:   state <= (cnt_nxt == LIMIT) ? ARB_FORCE : ARB_CPU;
            ARB_FORCE: state <= ARB_CPU;
            default:   state <= ARB_CPU;
         endcase
      end
   end

   // Read data only reaches the requester that issued the read; the other sees zero.
   assign cpu_rvalid = (rd_owner == OWN_CPU);
   assign ext_rvalid = (rd_owner == OWN_EXT);
   assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
   assign ext_rdata  = ext_rvalid ? mem_dout : '0;

endmodule
